sat_accum: RTL

//  Saturating signed accumulator. It drives the add/sub arithmetic interface
//  (A, B, SUB -> SUM, OV) from the initiator side and consumes its overflow flag.
//  It accepts a framed stream of NUM_SMPL signed operands over a valid/ready

---
 rtl/sat_accum_pkg.sv | 27 ++
 rtl/add_sub_ovf.sv | 30 +++
 rtl/sat_accum.sv | 99 +++++++++
 3 files changed

// File: rtl/sat_accum_pkg.sv
// Shared definitions for the saturating accumulator.
//   state_e      : FSM states IDLE / ACCUM / DONE
//   ACC_W        : default operand/accumulator width
//   SMAX / SMIN  : signed extremes at the default width
//   smax / smin  : the same extremes for any width (1..64), zero-extended to 64 bits
package sat_accum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam int unsigned ACC_W = 8;

    function automatic logic [63:0] smax(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    function automatic logic [63:0] smin(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/add_sub_ovf.sv
// Combinational two's-complement adder/subtractor with signed overflow flag.
//   a_i, b_i : operands (WIDTH, WIDTH >= 2)
//   sub_i    : 1 -> a - b, 0 -> a + b
//   sum_o    : WIDTH-bit wrapped result
//   ov_o     : signed overflow (carry into MSB xor carry out of MSB)
module add_sub_ovf #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             sub_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             ov_o
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH-1:0] lo;     // lo[WIDTH-1] is the carry into the MSB
    logic [1:0]       hi;     // {carry out of MSB, MSB sum bit}

    // Subtraction as a + ~b + 1; sub_i doubles as the carry-in.
    assign b_eff = sub_i ? ~b_i : b_i;
    assign lo    = {1'b0, a_i[WIDTH-2:0]} + {1'b0, b_eff[WIDTH-2:0]}
                 + {{(WIDTH-1){1'b0}}, sub_i};
    assign hi    = {1'b0, a_i[WIDTH-1]} + {1'b0, b_eff[WIDTH-1]}
                 + {1'b0, lo[WIDTH-1]};

    assign sum_o = {hi[0], lo[WIDTH-2:0]};
    assign ov_o  = lo[WIDTH-1] ^ hi[1];

endmodule

// File: rtl/sat_accum.sv
// Saturating signed accumulator over a framed valid/ready operand stream.
//   clk, rst_n : clock, synchronous active-low reset
//   start      : clear accumulator and begin a new frame (also restarts one in progress)
//   in_vld/in_data/in_sub/in_rdy : operand handshake; in_sub=1 subtracts
//   acc_out    : running (then final) accumulator value
//   acc_vld    : one-cycle pulse once NUM_SMPL operands have been taken
//   sat_flag   : sticky, a clamp happened somewhere in the current frame
module sat_accum
    import sat_accum_pkg::*;
#(
    parameter int WIDTH    = ACC_W,
    parameter int NUM_SMPL = 4,
    parameter int CNT_W    = $clog2(NUM_SMPL + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             in_vld,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_sub,
    output logic             in_rdy,
    output logic [WIDTH-1:0] acc_out,
    output logic             acc_vld,
    output logic             sat_flag
);

    localparam logic [WIDTH-1:0] SAT_HI = WIDTH'(smax(WIDTH));
    localparam logic [WIDTH-1:0] SAT_LO = WIDTH'(smin(WIDTH));
    localparam logic [CNT_W-1:0] LAST   = CNT_W'(NUM_SMPL);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             sat_q, sat_d;
    logic [WIDTH-1:0] sum;
    logic             ov;
    logic             xfer;

    add_sub_ovf #(.WIDTH(WIDTH)) u_addsub (
        .a_i   (acc_q),
        .b_i   (in_data),
        .sub_i (in_sub),
        .sum_o (sum),
        .ov_o  (ov)
    );

    // start takes priority over any operand offered in the same cycle.
    assign in_rdy  = (state_q == ST_ACCUM) & ~start;
    assign xfer    = in_vld & in_rdy;
    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        sat_d   = sat_q;
        if (start) begin
            // Same clear from every state; a partial frame is simply dropped.
            state_d = ST_ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            sat_d   = 1'b0;
        end else begin
            case (state_q)
                ST_ACCUM: begin
                    if (xfer) begin
                        // On overflow a wrapped-negative sum means the true result
                        // went past the top, and vice versa.
                        acc_d = ov ? (sum[WIDTH-1] ? SAT_HI : SAT_LO) : sum;
                        sat_d = sat_q | ov;
                        cnt_d = cnt_inc;
                        if (cnt_inc == LAST) state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sat_q   <= sat_d;
        end
    end

    assign acc_out  = acc_q;
    assign acc_vld  = (state_q == ST_DONE);
    assign sat_flag = sat_q;

endmodule
